// File: rtl/ddr_line_pingpong_buf.sv
// Two-bank line store between the DDR read path and the pixel output stage.
// Wide beats fill one bank while the other is serialised into pixels.
module ddr_line_pingpong_buf #(
  parameter int DQ_WIDTH  = 32,
  parameter int PIX_WIDTH = 16,
  parameter int H_WIDTH   = 1280,
  parameter int H_HEIGHT  = 720,
  parameter int CH_ROWS   = 4,
  parameter int CH_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buf_wr_en,
  input  logic [DQ_WIDTH*8-1:0] buf_wr_data,
  output logic                  axi_wr_buf_wait,
  output logic [CH_BITS-1:0]    channel_sel,
  output logic                  frame_done,
  output logic                  line_ready,
  input  logic                  rd_en,
  output logic                  de_o,
  output logic [PIX_WIDTH-1:0]  rgb_out,
  input  logic                  clr_err,
  output logic                  ovf,
  output logic                  udf
);
  localparam int BW     = DQ_WIDTH * 8;
  localparam int PPB    = BW / PIX_WIDTH;
  localparam int BPL    = H_WIDTH / PPB;
  localparam int TILE_H = H_HEIGHT / CH_ROWS;
  localparam int BCW    = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int PCW    = (PPB > 1) ? $clog2(PPB) : 1;
  localparam int RCW    = (H_HEIGHT > 1) ? $clog2(H_HEIGHT) : 1;

  // Depth is a power of two so the {bank, beat} address never falls off the end.
  logic [BW-1:0] mem_q [0:(2**(BCW+1))-1];

  logic [BCW-1:0]       beat_cnt_q, beat_cnt_d, rd_beat_q, rd_beat_d;
  logic [PCW-1:0]       rd_pix_q, rd_pix_d;
  logic [RCW-1:0]       row_cnt_q, row_cnt_d;
  logic [1:0]           full_q, full_d;
  logic                 wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic                 wait_q, wait_d, fd_q, fd_d, de_q, de_d, ovf_q, ovf_d, udf_q, udf_d;
  logic [CH_BITS-1:0]   ch_q, ch_d;
  logic [PIX_WIDTH-1:0] rgb_q, rgb_d;
  logic [BW-1:0]        rd_word;
  logic [PIX_WIDTH-1:0] rd_pixel;
  logic                 wr_acc, wr_last, rd_acc, rd_beat_end, rd_last;

  // Write handshake: a beat transfers when buf_wr_en=1 and axi_wr_buf_wait=0;
  // a beat offered while waiting is lost and flagged. Reads transfer on
  // rd_en=1 with line_ready=1, and the pixel appears one cycle later on de_o.
  always_comb begin
    rd_word  = mem_q[{rd_bank_q, rd_beat_q}];
    rd_pixel = rd_word[int'(rd_pix_q)*PIX_WIDTH +: PIX_WIDTH];

    wr_acc      = buf_wr_en & ~wait_q;
    wr_last     = wr_acc & (beat_cnt_q == BCW'(BPL - 1));
    rd_acc      = rd_en & full_q[rd_bank_q];
    rd_beat_end = rd_acc & (rd_pix_q == PCW'(PPB - 1));
    rd_last     = rd_beat_end & (rd_beat_q == BCW'(BPL - 1));

    beat_cnt_d = beat_cnt_q;
    rd_beat_d  = rd_beat_q;
    rd_pix_d   = rd_pix_q;
    row_cnt_d  = row_cnt_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    ch_d       = ch_q;
    fd_d       = 1'b0;

    if (wr_acc) beat_cnt_d = wr_last ? '0 : beat_cnt_q + 1'b1;
    if (wr_last) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
      if (row_cnt_q == RCW'(H_HEIGHT - 1)) begin
        row_cnt_d = '0;
        fd_d      = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
      end
      ch_d = CH_BITS'(int'(row_cnt_d) / TILE_H);
    end

    if (rd_acc) rd_pix_d = rd_beat_end ? '0 : rd_pix_q + 1'b1;
    if (rd_beat_end) rd_beat_d = rd_last ? '0 : rd_beat_q + 1'b1;
    // The freed bank is never the one being filled, so this cannot undo a set above.
    if (rd_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    wait_d = full_d[0] & full_d[1];
    de_d   = rd_acc;
    rgb_d  = rd_acc ? rd_pixel : rgb_q;
    ovf_d  = (ovf_q & ~clr_err) | (buf_wr_en & wait_q);
    udf_d  = (udf_q & ~clr_err) | (rd_en & ~full_q[rd_bank_q]);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[{wr_bank_q, beat_cnt_q}] <= buf_wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q <= '0;
      rd_beat_q  <= '0;
      rd_pix_q   <= '0;
      row_cnt_q  <= '0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wait_q     <= 1'b0;
      fd_q       <= 1'b0;
      de_q       <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      ch_q       <= '0;
      rgb_q      <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      rd_beat_q  <= rd_beat_d;
      rd_pix_q   <= rd_pix_d;
      row_cnt_q  <= row_cnt_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wait_q     <= wait_d;
      fd_q       <= fd_d;
      de_q       <= de_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      ch_q       <= ch_d;
      rgb_q      <= rgb_d;
    end
  end

  assign axi_wr_buf_wait = wait_q;
  assign channel_sel     = ch_q;
  assign frame_done      = fd_q;
  assign line_ready      = full_q[rd_bank_q];
  assign de_o            = de_q;
  assign rgb_out         = rgb_q;
  assign ovf             = ovf_q;
  assign udf             = udf_q;
endmodule

// File: tb/tb_ddr_line_pingpong_buf.sv
// Bench for ddr_line_pingpong_buf: fixed vector table, directed corner sequences
// and random traffic compared against a queue-based line model.
module tb_ddr_line_pingpong_buf;
  localparam int DQ_W = 32, PIX_W = 16, H_W = 64, H_H = 8, CH_R = 2, CH_B = 2;
  localparam int BW = DQ_W * 8, PPB = BW / PIX_W, TILE_H = H_H / CH_R;

  logic clk = 1'b0, rst = 1'b0;
  logic buf_wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [BW-1:0] buf_wr_data = '0;
  logic axi_wr_buf_wait, frame_done, line_ready, de_o, ovf, udf;
  logic [CH_B-1:0] channel_sel;
  logic [PIX_W-1:0] rgb_out;

  ddr_line_pingpong_buf #(
    .DQ_WIDTH(DQ_W), .PIX_WIDTH(PIX_W), .H_WIDTH(H_W), .H_HEIGHT(H_H),
    .CH_ROWS(CH_R), .CH_BITS(CH_B)
  ) dut (
    .clk(clk), .rst(rst), .buf_wr_en(buf_wr_en), .buf_wr_data(buf_wr_data),
    .axi_wr_buf_wait(axi_wr_buf_wait), .channel_sel(channel_sel),
    .frame_done(frame_done), .line_ready(line_ready), .rd_en(rd_en),
    .de_o(de_o), .rgb_out(rgb_out), .clr_err(clr_err), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: stored lines are a flat pixel queue read from the head.
  logic [PIX_W-1:0] m_pix[$];
  logic [PIX_W-1:0] m_part[$];
  int m_lines, m_rdcnt, m_rows;
  logic m_wait, m_fd, m_ovf, m_udf, m_de;
  logic [PIX_W-1:0] m_rgb;
  logic [CH_B-1:0] m_ch;

  task automatic model_reset();
    m_pix.delete(); m_part.delete();
    m_lines = 0; m_rdcnt = 0; m_rows = 0;
    m_wait = 0; m_fd = 0; m_ovf = 0; m_udf = 0; m_de = 0; m_rgb = '0; m_ch = '0;
  endtask

  task automatic model_step(input logic w, input logic [BW-1:0] d, input logic r, input logic c);
    bit ready, freed;
    ready = (m_lines > 0);
    freed = 0;
    m_fd = 0;
    m_de = 0;
    m_udf = (m_udf && !c) || (r && !ready);
    m_ovf = (m_ovf && !c) || (w && m_wait);
    if (r && ready) begin
      m_de = 1;
      m_rgb = m_pix.pop_front();
      m_rdcnt++;
      if (m_rdcnt == H_W) begin m_rdcnt = 0; freed = 1; end
    end
    if (w && !m_wait) begin
      for (int i = 0; i < PPB; i++) m_part.push_back(d[i*PIX_W +: PIX_W]);
      if (m_part.size() == H_W) begin
        foreach (m_part[i]) m_pix.push_back(m_part[i]);
        m_part.delete();
        m_lines++;
        m_rows = (m_rows + 1) % H_H;
        m_fd = (m_rows == 0);
        m_ch = CH_B'(m_rows / TILE_H);
      end
    end
    if (freed) m_lines--;
    m_wait = (m_lines == 2);
  endtask

  task automatic cmp_model();
    chk("de_o", de_o, m_de);
    chk("rgb_out", rgb_out, m_rgb);
    chk("wait", axi_wr_buf_wait, m_wait);
    chk("line_ready", line_ready, m_lines > 0);
    chk("channel_sel", channel_sel, m_ch);
    chk("frame_done", frame_done, m_fd);
    chk("ovf", ovf, m_ovf);
    chk("udf", udf, m_udf);
  endtask

  task automatic cycle(input logic w, input logic [BW-1:0] d, input logic r, input logic c);
    @(negedge clk);
    buf_wr_en = w; buf_wr_data = d; rd_en = r; clr_err = c;
    @(posedge clk);
    model_step(w, d, r, c);
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; buf_wr_en = 0; rd_en = 0; clr_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wait", axi_wr_buf_wait, 0);
    chk("rst_ch", channel_sel, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_ready", line_ready, 0);
    chk("rst_de", de_o, 0);
    chk("rst_rgb", rgb_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [BW-1:0] make_beat(input int base);
    logic [BW-1:0] b;
    for (int i = 0; i < PPB; i++) b[i*PIX_W +: PIX_W] = PIX_W'(base + i);
    return b;
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] b;
    for (int k = 0; k < BW / 32; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  typedef struct {
    logic wr, rd, clr;
    logic e_de, e_wait, e_rdy, e_ovf, e_udf;
  } vec_t;
  vec_t tbl[14];

  int beats, fd_cnt;
  logic acc;

  initial begin
    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 1, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 1, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 1, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 1, 1, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 1, 1, 1, 0};
    tbl[11] = '{1, 0, 1, 0, 1, 1, 1, 0};
    tbl[12] = '{0, 0, 1, 0, 1, 1, 0, 0};
    tbl[13] = '{0, 1, 0, 1, 1, 1, 0, 0};

    // Line fill then a 64-pixel drain in order.
    do_reset();
    for (int b = 0; b < 4; b++) begin
      cycle(1, make_beat(b * PPB), 0, 0);
      chk("t1_ready", line_ready, b == 3);
    end
    for (int i = 0; i < H_W; i++) begin
      cycle(0, '0, 1, 0);
      chk("t1_de", de_o, 1);
      chk("t1_pix", rgb_out, i);
    end
    cycle(0, '0, 0, 0);
    chk("t1_de_end", de_o, 0);
    chk("t1_ready_end", line_ready, 0);

    // Underflow/clear, two lines, dropped beat, error clear priority.
    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].wr, rand_beat(), tbl[i].rd, tbl[i].clr);
      chk($sformatf("tbl%0d_de", i), de_o, tbl[i].e_de);
      chk($sformatf("tbl%0d_wait", i), axi_wr_buf_wait, tbl[i].e_wait);
      chk($sformatf("tbl%0d_rdy", i), line_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].e_ovf);
      chk($sformatf("tbl%0d_udf", i), udf, tbl[i].e_udf);
    end
    for (int i = 1; i < H_W - 1; i++) cycle(0, '0, 1, 0);
    chk("t2_wait_held", axi_wr_buf_wait, 1);
    cycle(0, '0, 1, 0);
    chk("t2_wait_free", axi_wr_buf_wait, 0);

    // Full frame with continuous reads: channel_sel and frame_done.
    do_reset();
    beats = 0;
    fd_cnt = 0;
    for (int t = 0; t < 2000 && beats < 32; t++) begin
      acc = !m_wait;
      cycle(acc, make_beat(beats * PPB), 1, 0);
      if (frame_done) fd_cnt++;
      if (acc) begin
        beats++;
        if (beats == 16) chk("t3_ch_line4", channel_sel, 1);
        if (beats == 32) begin
          chk("t3_ch_line8", channel_sel, 0);
          chk("t3_fd_beat32", frame_done, 1);
        end
      end
    end
    chk("t3_beats", beats, 32);
    chk("t3_fd_count", fd_cnt, 1);

    // Line completion on write coincides with line free on read.
    do_reset();
    for (int b = 0; b < 4; b++) cycle(1, make_beat(b * PPB), 0, 0);
    for (int r = 0; r < H_W; r++)
      cycle(r >= H_W - 4, make_beat(H_W + (r - (H_W - 4)) * PPB), 1, 0);
    chk("t5_wait", axi_wr_buf_wait, 0);
    chk("t5_ready", line_ready, 1);
    for (int r = 0; r < H_W; r++) cycle(0, '0, 1, 0);

    // Reset after a partial line: only the following line is read back.
    do_reset();
    for (int b = 0; b < 2; b++) cycle(1, make_beat(1000 + b * PPB), 0, 0);
    do_reset();
    for (int b = 0; b < 4; b++) cycle(1, make_beat(500 + b * PPB), 0, 0);
    for (int i = 0; i < H_W; i++) begin
      cycle(0, '0, 1, 0);
      chk("t6_pix", rgb_out, 500 + i);
    end

    // Random traffic against the model.
    do_reset();
    for (int t = 0; t < 3000; t++)
      cycle($urandom_range(0, 3) != 0, rand_beat(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
